// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: funct3 branch encodings,
// 2-bit predictor counter states and the counter step function.
package branch_resolve_unit_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV0 = 3'b010;
    localparam logic [2:0] F3_RSV1 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = BHT_WNT;

    typedef struct packed {
        logic valid;
        logic do_branch;
        logic mispredict;
        logic illegal;
    } result_t;

    // Saturating step of a 2-bit predictor counter toward the resolved outcome.
    function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
        bht_state_e nxt;
        nxt = cur;
        case (cur)
            BHT_SNT: nxt = taken ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = taken ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = taken ? BHT_ST  : BHT_WNT;
            BHT_ST:  nxt = taken ? BHT_ST  : BHT_WT;
            default: nxt = BHT_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Branch condition evaluator: decodes funct3 into a taken decision and flags
// the two reserved encodings as illegal. Purely combinational.
module branch_resolve_unit_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      f3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (f3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            F3_RSV0,
            F3_RSV1: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions, trains a flop-based
// table of 2-bit predictors, reports a registered result and keeps statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [XLEN-1:0]  i_lookup_pc,
    output logic             o_pred_taken,
    input  logic             i_valid,
    input  logic             i_Branch,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [2:0]       i_f3,
    input  logic             i_pred_taken,
    input  logic             i_flush,
    output logic             o_valid,
    output logic             o_DoBranch,
    output logic             o_mispredict,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_branch_count,
    output logic [CNT_W-1:0] o_mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;
    logic             cmp_taken;
    logic             cmp_illegal;
    logic             upd_en;
    logic             mis_event;
    logic             unused_pc;

    logic [2*BHT_ENTRIES-1:0] bht_vec;

    result_t          res_reg;
    result_t          res_next;
    logic [CNT_W-1:0] branch_count_reg;
    logic [CNT_W-1:0] mispredict_count_reg;

    assign upd_idx    = i_pc[IDX_W+1:2];
    assign lookup_idx = i_lookup_pc[IDX_W+1:2];
    assign unused_pc  = ^{i_pc[1:0], i_pc[XLEN-1:IDX_W+2],
                          i_lookup_pc[1:0], i_lookup_pc[XLEN-1:IDX_W+2]};

    branch_resolve_unit_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .rs1     (i_rs1),
        .rs2     (i_rs2),
        .f3      (i_f3),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // Only legal conditional branches train the table; a flush does not cancel training.
    assign upd_en    = i_valid & i_Branch & ~cmp_illegal;
    assign mis_event = i_valid & (i_Branch ? (~cmp_illegal & (cmp_taken ^ i_pred_taken))
                                           : i_pred_taken);

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            bht_state_e state_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    state_reg <= BHT_RESET;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    state_reg <= bht_next(state_reg, cmp_taken);
                end
            end

            assign bht_vec[2*gi +: 2] = state_reg;
        end
    endgenerate

    // Lookup reads the current flops, so a same-cycle update is not bypassed.
    assign o_pred_taken = bht_vec[{lookup_idx, 1'b1}];

    always_comb begin
        res_next = '0;
        if (i_valid && !i_flush) begin
            res_next.valid = 1'b1;
            if (i_Branch) begin
                if (cmp_illegal) begin
                    res_next.illegal = 1'b1;
                end else begin
                    res_next.do_branch  = cmp_taken;
                    res_next.mispredict = cmp_taken ^ i_pred_taken;
                end
            end else begin
                res_next.mispredict = i_pred_taken;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_reg <= '0;
        end else begin
            res_reg <= res_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            if (upd_en && (branch_count_reg != '1)) begin
                branch_count_reg <= branch_count_reg + 1'b1;
            end
            if (mis_event && (mispredict_count_reg != '1)) begin
                mispredict_count_reg <= mispredict_count_reg + 1'b1;
            end
        end
    end

    assign o_valid            = res_reg.valid;
    assign o_DoBranch         = res_reg.do_branch;
    assign o_mispredict       = res_reg.mispredict;
    assign o_illegal          = res_reg.illegal;
    assign o_branch_count     = branch_count_reg;
    assign o_mispredict_count = mispredict_count_reg;

endmodule
